// File: rtl/alu_wb_if.sv
// Handshake bundle between the ALU result side, the register-file write port
// and the status outputs of the writeback serializer.
interface alu_wb_if #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned AW    = 5
);
   localparam int unsigned OW = $clog2(DEPTH) + 1;

   logic          in_valid;
   logic          in_ready;
   logic [63:0]   in_result;
   logic          in_wide;
   logic [AW-1:0] in_rd;
   logic [3:0]    in_flags;
   logic          wb_valid;
   logic          wb_ready;
   logic [31:0]   wb_data;
   logic [AW-1:0] wb_rd;
   logic          wb_last;
   logic [3:0]    flags_q;
   logic [OW-1:0] occupancy;

   modport slave (
      input  in_valid, in_result, in_wide, in_rd, in_flags, wb_ready,
      output in_ready, wb_valid, wb_data, wb_rd, wb_last, flags_q, occupancy
   );

   modport master (
      output in_valid, in_result, in_wide, in_rd, in_flags, wb_ready,
      input  in_ready, wb_valid, wb_data, wb_rd, wb_last, flags_q, occupancy
   );
endinterface

// File: rtl/alu_wb_serializer.sv
// ALU writeback stage: buffers results in a small FIFO and serialises them onto
// a 32-bit register-file write port (wide products as two beats rd, rd+1).
module alu_wb_serializer #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned AW    = 5
) (
   input  logic     clk,
   input  logic     rst,
   alu_wb_if.slave  bus
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned OW = PW + 1;

   typedef enum logic {LO = 1'b0, HI = 1'b1} beat_t;

   typedef struct packed {
      logic [63:0]   result;
      logic          wide;
      logic [AW-1:0] rd;
      logic [3:0]    flags;
   } entry_t;

   entry_t        mem_q [DEPTH];
   entry_t        in_entry;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [OW-1:0] occ_q, occ_d;
   beat_t         state_q, state_d;
   logic [3:0]    flags_r, flags_d;
   logic          in_ready_q, in_ready_d;
   logic          wb_valid_q, wb_valid_d;
   logic          wb_last_q, wb_last_d;
   logic [31:0]   wb_data_q, wb_data_d;
   logic [AW-1:0] wb_rd_q, wb_rd_d;
   logic          head_wide;
   logic [3:0]    head_flags;
   logic [63:0]   nh_result;
   logic          nh_wide;
   logic [AW-1:0] nh_rd;
   logic          push, hs, pop;

   // Narrow results drop the upper half so stale bits never reach a HI beat.
   always_comb begin
      in_entry.result = bus.in_wide ? bus.in_result : {32'd0, bus.in_result[31:0]};
      in_entry.wide   = bus.in_wide;
      in_entry.rd     = bus.in_rd;
      in_entry.flags  = bus.in_flags;
   end

   assign head_wide  = mem_q[rd_ptr_q].wide;
   assign head_flags = mem_q[rd_ptr_q].flags;

   assign push = bus.in_valid && in_ready_q;
   assign hs   = wb_valid_q && bus.wb_ready;
   assign pop  = hs && wb_last_q;

   // Next-state logic; all port outputs are precomputed here and registered.
   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      occ_d      = occ_q;
      flags_d    = flags_r;
      wb_valid_d = 1'b0;
      wb_last_d  = 1'b0;
      wb_data_d  = 32'd0;
      wb_rd_d    = '0;

      if (hs) begin
         if (state_q == LO) state_d = head_wide ? HI : LO;
         else               state_d = LO;
      end

      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
         flags_d  = head_flags;
      end

      if (push && !pop)      occ_d = occ_q + OW'(1);
      else if (pop && !push) occ_d = occ_q - OW'(1);

      in_ready_d = (occ_d != OW'(DEPTH));

      // The head after this edge is either the slot being written now or old contents.
      if (push && (wr_ptr_q == rd_ptr_d)) begin
         nh_result = in_entry.result;
         nh_wide   = in_entry.wide;
         nh_rd     = in_entry.rd;
      end else begin
         nh_result = mem_q[rd_ptr_d].result;
         nh_wide   = mem_q[rd_ptr_d].wide;
         nh_rd     = mem_q[rd_ptr_d].rd;
      end

      if (occ_d != OW'(0)) begin
         wb_valid_d = 1'b1;
         if (state_d == HI) begin
            wb_data_d = nh_result[63:32];
            wb_rd_d   = AW'(nh_rd + AW'(1));
            wb_last_d = 1'b1;
         end else begin
            wb_data_d = nh_result[31:0];
            wb_rd_d   = nh_rd;
            wb_last_d = !nh_wide;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
         state_q    <= LO;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         occ_q      <= '0;
         flags_r    <= 4'd0;
         in_ready_q <= 1'b1;
         wb_valid_q <= 1'b0;
         wb_last_q  <= 1'b0;
         wb_data_q  <= 32'd0;
         wb_rd_q    <= '0;
      end else begin
         if (push) mem_q[wr_ptr_q] <= in_entry;
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         occ_q      <= occ_d;
         flags_r    <= flags_d;
         in_ready_q <= in_ready_d;
         wb_valid_q <= wb_valid_d;
         wb_last_q  <= wb_last_d;
         wb_data_q  <= wb_data_d;
         wb_rd_q    <= wb_rd_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.wb_valid  = wb_valid_q;
   assign bus.wb_last   = wb_last_q;
   assign bus.wb_data   = wb_data_q;
   assign bus.wb_rd     = wb_rd_q;
   assign bus.flags_q   = flags_r;
   assign bus.occupancy = occ_q;
endmodule

// File: tb/tb_alu_wb_serializer.sv
// Bench for alu_wb_serializer: directed scenarios plus a randomized run checked
// against a queue-based model of entries and beats.
module tb_alu_wb_serializer;
   localparam int unsigned DEPTH = 2;
   localparam int unsigned AW    = 5;

   typedef struct {
      logic [63:0] result;
      logic        wide;
      logic [4:0]  rd;
      logic [3:0]  flags;
   } ment_t;

   logic clk;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;

   alu_wb_if #(.DEPTH(DEPTH), .AW(AW)) bus ();

   alu_wb_serializer #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [63:0] r, input logic w,
                        input logic [4:0] rd, input logic [3:0] f);
      bus.in_valid  = v;
      bus.in_result = r;
      bus.in_wide   = w;
      bus.in_rd     = rd;
      bus.in_flags  = f;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.wb_ready = 1'b0;
      drive(1'b0, 64'd0, 1'b0, 5'd0, 4'd0);
      tick(); tick();
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
      n_cmp++; if (bus.wb_valid !== 1'b0) begin n_err++; $display("FAIL reset_wb_valid: got %b want 0", bus.wb_valid); end
      n_cmp++; if (bus.wb_last !== 1'b0) begin n_err++; $display("FAIL reset_wb_last: got %b want 0", bus.wb_last); end
      n_cmp++; if (bus.flags_q !== 4'd0) begin n_err++; $display("FAIL reset_flags: got %h want 0", bus.flags_q); end
      n_cmp++; if (bus.occupancy !== 2'd0) begin n_err++; $display("FAIL reset_occ: got %0d want 0", bus.occupancy); end
      n_cmp++; if (bus.wb_data !== 32'd0) begin n_err++; $display("FAIL reset_wb_data: got %h want 0", bus.wb_data); end
      rst = 1'b0;
      tick(); tick();
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL idle_in_ready: got %b want 1", bus.in_ready); end
      n_cmp++; if (bus.wb_valid !== 1'b0) begin n_err++; $display("FAIL idle_wb_valid: got %b want 0", bus.wb_valid); end
   endtask

   task automatic test_narrow();
      bus.wb_ready = 1'b1;
      drive(1'b1, 64'h0000_0000_0000_0007, 1'b0, 5'd3, 4'b0000);
      tick();
      drive(1'b0, 64'd0, 1'b0, 5'd0, 4'd0);
      n_cmp++; if (bus.wb_valid !== 1'b1) begin n_err++; $display("FAIL narrow_valid: got %b want 1", bus.wb_valid); end
      n_cmp++; if (bus.wb_data !== 32'd7) begin n_err++; $display("FAIL narrow_data: got %h want 7", bus.wb_data); end
      n_cmp++; if (bus.wb_rd !== 5'd3) begin n_err++; $display("FAIL narrow_rd: got %0d want 3", bus.wb_rd); end
      n_cmp++; if (bus.wb_last !== 1'b1) begin n_err++; $display("FAIL narrow_last: got %b want 1", bus.wb_last); end
      tick();
      n_cmp++; if (bus.wb_valid !== 1'b0) begin n_err++; $display("FAIL narrow_done_valid: got %b want 0", bus.wb_valid); end
      n_cmp++; if (bus.flags_q !== 4'd0) begin n_err++; $display("FAIL narrow_flags: got %h want 0", bus.flags_q); end
      n_cmp++; if (bus.occupancy !== 2'd0) begin n_err++; $display("FAIL narrow_occ: got %0d want 0", bus.occupancy); end
   endtask

   task automatic test_wide();
      bus.wb_ready = 1'b1;
      drive(1'b1, 64'h0000_0001_FFFF_FFFE, 1'b1, 5'd31, 4'b0000);
      tick();
      drive(1'b0, 64'd0, 1'b0, 5'd0, 4'd0);
      n_cmp++; if (bus.wb_data !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL wide_lo_data: got %h want fffffffe", bus.wb_data); end
      n_cmp++; if (bus.wb_rd !== 5'd31) begin n_err++; $display("FAIL wide_lo_rd: got %0d want 31", bus.wb_rd); end
      n_cmp++; if (bus.wb_last !== 1'b0) begin n_err++; $display("FAIL wide_lo_last: got %b want 0", bus.wb_last); end
      tick();
      n_cmp++; if (bus.wb_valid !== 1'b1) begin n_err++; $display("FAIL wide_hi_valid: got %b want 1", bus.wb_valid); end
      n_cmp++; if (bus.wb_data !== 32'h0000_0001) begin n_err++; $display("FAIL wide_hi_data: got %h want 1", bus.wb_data); end
      n_cmp++; if (bus.wb_rd !== 5'd0) begin n_err++; $display("FAIL wide_hi_rd: got %0d want 0", bus.wb_rd); end
      n_cmp++; if (bus.wb_last !== 1'b1) begin n_err++; $display("FAIL wide_hi_last: got %b want 1", bus.wb_last); end
      tick();
      n_cmp++; if (bus.wb_valid !== 1'b0) begin n_err++; $display("FAIL wide_done_valid: got %b want 0", bus.wb_valid); end
   endtask

   task automatic test_full();
      bus.wb_ready = 1'b0;
      drive(1'b1, 64'h11, 1'b0, 5'd1, 4'b0001);
      tick();
      n_cmp++; if (bus.occupancy !== 2'd1) begin n_err++; $display("FAIL full_occ1: got %0d want 1", bus.occupancy); end
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL full_ready1: got %b want 1", bus.in_ready); end
      drive(1'b1, 64'h22, 1'b0, 5'd2, 4'b0010);
      tick();
      n_cmp++; if (bus.occupancy !== 2'd2) begin n_err++; $display("FAIL full_occ2: got %0d want 2", bus.occupancy); end
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL full_ready0: got %b want 0", bus.in_ready); end
      drive(1'b1, 64'h33, 1'b0, 5'd4, 4'b0011);
      tick();
      n_cmp++; if (bus.occupancy !== 2'd2) begin n_err++; $display("FAIL full_refuse_occ: got %0d want 2", bus.occupancy); end
      n_cmp++; if (bus.wb_data !== 32'h11) begin n_err++; $display("FAIL full_stable_data: got %h want 11", bus.wb_data); end
      n_cmp++; if (bus.wb_rd !== 5'd1) begin n_err++; $display("FAIL full_stable_rd: got %0d want 1", bus.wb_rd); end
      bus.wb_ready = 1'b1;
      tick();
      n_cmp++; if (bus.occupancy !== 2'd1) begin n_err++; $display("FAIL full_pop_occ: got %0d want 1", bus.occupancy); end
      n_cmp++; if (bus.wb_data !== 32'h22) begin n_err++; $display("FAIL full_second_data: got %h want 22", bus.wb_data); end
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL full_ready_rise: got %b want 1", bus.in_ready); end
      drive(1'b0, 64'd0, 1'b0, 5'd0, 4'd0);
      tick();
      n_cmp++; if (bus.wb_valid !== 1'b0) begin n_err++; $display("FAIL full_drain_valid: got %b want 0", bus.wb_valid); end
      n_cmp++; if (bus.flags_q !== 4'b0010) begin n_err++; $display("FAIL full_flags: got %b want 0010", bus.flags_q); end
   endtask

   task automatic test_flags_stall();
      bus.wb_ready = 1'b1;
      drive(1'b1, 64'h0000_00AB_0000_00CD, 1'b1, 5'd7, 4'b0100);
      tick();
      drive(1'b0, 64'd0, 1'b0, 5'd0, 4'd0);
      n_cmp++; if (bus.wb_data !== 32'hCD) begin n_err++; $display("FAIL stall_lo_data: got %h want cd", bus.wb_data); end
      tick();
      bus.wb_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         n_cmp++; if (bus.flags_q !== 4'b0010) begin n_err++; $display("FAIL stall_flags_held: got %b want 0010", bus.flags_q); end
         n_cmp++; if (bus.wb_data !== 32'hAB || bus.wb_rd !== 5'd8 || bus.wb_last !== 1'b1)
            begin n_err++; $display("FAIL stall_hi_beat: got %h@%0d last %b want ab@8 last 1", bus.wb_data, bus.wb_rd, bus.wb_last); end
         tick();
      end
      bus.wb_ready = 1'b1;
      tick();
      n_cmp++; if (bus.flags_q !== 4'b0100) begin n_err++; $display("FAIL stall_flags_load: got %b want 0100", bus.flags_q); end
      n_cmp++; if (bus.wb_valid !== 1'b0) begin n_err++; $display("FAIL stall_done_valid: got %b want 0", bus.wb_valid); end
   endtask

   task automatic test_reset_mid();
      bus.wb_ready = 1'b1;
      drive(1'b1, 64'h5555_0000_0000_6666, 1'b1, 5'd10, 4'b1111);
      tick();
      drive(1'b0, 64'd0, 1'b0, 5'd0, 4'd0);
      tick();
      bus.wb_ready = 1'b0;
      n_cmp++; if (bus.wb_data !== 32'h5555_0000) begin n_err++; $display("FAIL rmid_hi_data: got %h want 55550000", bus.wb_data); end
      #2 rst = 1'b1;
      #1;
      n_cmp++; if (bus.wb_valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid: got %b want 0", bus.wb_valid); end
      n_cmp++; if (bus.occupancy !== 2'd0) begin n_err++; $display("FAIL rmid_occ: got %0d want 0", bus.occupancy); end
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rmid_ready: got %b want 1", bus.in_ready); end
      n_cmp++; if (bus.flags_q !== 4'd0) begin n_err++; $display("FAIL rmid_flags: got %b want 0", bus.flags_q); end
      tick();
      rst = 1'b0;
      bus.wb_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_cmp++; if (bus.wb_valid !== 1'b0) begin n_err++; $display("FAIL rmid_no_hi: cycle %0d wb_valid %b want 0", i, bus.wb_valid); end
      end
   endtask

   task automatic test_random();
      ment_t       q[$];
      ment_t       e;
      int          beat;
      logic [3:0]  mflags;
      logic [63:0] r;
      logic        exp_valid, exp_last, push, hs;
      logic [31:0] exp_data;
      logic [4:0]  exp_rd;

      rst = 1'b1;
      drive(1'b0, 64'd0, 1'b0, 5'd0, 4'd0);
      bus.wb_ready = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      beat = 0;
      mflags = 4'd0;
      for (int c = 0; c < 600; c++) begin
         r = {$urandom(), $urandom()};
         drive(($urandom_range(0, 9) < 7), r, 1'($urandom_range(0, 1)),
               5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)));
         bus.wb_ready = ($urandom_range(0, 9) < 6);

         exp_valid = (q.size() != 0);
         exp_data  = 32'd0;
         exp_rd    = 5'd0;
         exp_last  = 1'b0;
         if (exp_valid) begin
            r = q[0].result;
            if (beat == 1) begin
               exp_data = r[63:32];
               exp_rd   = 5'((int'(q[0].rd) + 1) % 32);
               exp_last = 1'b1;
            end else begin
               exp_data = r[31:0];
               exp_rd   = q[0].rd;
               exp_last = !q[0].wide;
            end
         end
         n_cmp++; if (bus.in_ready !== (q.size() < DEPTH)) begin n_err++; $display("FAIL rnd_in_ready c%0d: got %b want %b", c, bus.in_ready, (q.size() < DEPTH)); end
         n_cmp++; if (bus.occupancy !== 2'(q.size())) begin n_err++; $display("FAIL rnd_occ c%0d: got %0d want %0d", c, bus.occupancy, q.size()); end
         n_cmp++; if (bus.wb_valid !== exp_valid) begin n_err++; $display("FAIL rnd_valid c%0d: got %b want %b", c, bus.wb_valid, exp_valid); end
         n_cmp++; if (bus.wb_data !== exp_data) begin n_err++; $display("FAIL rnd_data c%0d: got %h want %h", c, bus.wb_data, exp_data); end
         n_cmp++; if (bus.wb_rd !== exp_rd) begin n_err++; $display("FAIL rnd_rd c%0d: got %0d want %0d", c, bus.wb_rd, exp_rd); end
         n_cmp++; if (bus.wb_last !== exp_last) begin n_err++; $display("FAIL rnd_last c%0d: got %b want %b", c, bus.wb_last, exp_last); end
         n_cmp++; if (bus.flags_q !== mflags) begin n_err++; $display("FAIL rnd_flags c%0d: got %b want %b", c, bus.flags_q, mflags); end

         push = bus.in_valid && (q.size() < DEPTH);
         hs   = exp_valid && bus.wb_ready;
         e.result = bus.in_result;
         e.wide   = bus.in_wide;
         e.rd     = bus.in_rd;
         e.flags  = bus.in_flags;
         if (hs) begin
            if (beat == 0 && q[0].wide) begin
               beat = 1;
            end else begin
               mflags = q[0].flags;
               void'(q.pop_front());
               beat = 0;
            end
         end
         if (push) q.push_back(e);
         tick();
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.wb_ready = 1'b0;
      drive(1'b0, 64'd0, 1'b0, 5'd0, 4'd0);
      test_reset();
      test_narrow();
      test_wide();
      test_full();
      test_flags_stall();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
